msgpass_rd_addr_sched: RTL and testbench
========================================

Name: msgpass_rd_addr_sched

Overview:
- Read-address scheduler for the message-pass buffer of the layered LDPC decoder. Replaces the constant-base bypass model.
- Holds a programmable table of per-layer base addresses, one per SCU.memShare() target region.
- Sequences read addresses through iterations (outer loop), layers (middle loop) and rows within a layer (inner loop).
- Delivers each address to the memShare request path over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 8, read-address width. Matches memShare_config_pkg::MSGPASS_RD_ADDR_WIDTH.
- BASE_NUM, 4, number of base addresses, equal to the number of layers per iteration.
- ROW_NUM, 8, reads issued per layer. Row offsets are 0..ROW_NUM-1.
- ITER_WIDTH, 4, width of the iteration-count input.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- cfg_we_i  input  1  base-table write strobe.
- cfg_sel_i  input  $clog2(BASE_NUM)  base-table write index.
- cfg_baseAddr_i  input  ADDR_WIDTH  base-table write data.
- start_i  input  1  start request, one-cycle pulse.
- iter_num_i  input  ITER_WIDTH  number of iterations; sampled on an accepted start.
- msgPass_rdAddr_o  output  ADDR_WIDTH  current read address.
- addr_valid_o  output  1  msgPass_rdAddr_o is valid.
- addr_ready_i  input  1  consumer accepts the address.
- layer_id_o  output  $clog2(BASE_NUM)  layer of the current address.
- layer_last_o  output  1  current address is the last row of its layer.
- busy_o  output  1  schedule in progress.
- done_o  output  1  one-cycle pulse when the schedule completes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - All counters and all table entries = 0.
  - msgPass_rdAddr_o=0, addr_valid_o=0, layer_id_o=0, layer_last_o=0, busy_o=0, done_o=0.
  - Reset asserted mid-schedule aborts the schedule immediately; no done_o is produced.
- Table write:
  - In IDLE, cfg_we_i=1 writes table[cfg_sel_i]=cfg_baseAddr_i on that edge.
  - Writes are ignored in every other state.
  - If cfg_sel_i >= BASE_NUM, the write is ignored.
- FSM states: IDLE, PREP, RUN, DONE.
  - IDLE: start_i=1 goes to PREP.
    - On that edge: latch iter_num_i (0 is treated as 1); clear iter_cnt, layer_cnt and row_cnt.
    - A simultaneous cfg_we_i and start_i: the write completes first, and PREP sees the new value.
  - PREP: one cycle with busy_o=1 and addr_valid_o=0.
    - Registers msgPass_rdAddr_o = table[0] + 0.
    - Next state is RUN.
  - RUN: addr_valid_o=1.
    - Output address = table[layer_cnt] + row_cnt, truncated to ADDR_WIDTH (modulo 2^ADDR_WIDTH wrap, no saturation).
    - layer_last_o = (row_cnt == ROW_NUM-1). layer_id_o = layer_cnt.
    - Outputs are registered and held stable while addr_valid_o=1 and addr_ready_i=0. No address is skipped or repeated.
    - On valid&&ready the address is consumed:
      - row_cnt increments.
      - When row_cnt wraps to 0, layer_cnt increments.
      - When layer_cnt wraps to 0, iter_cnt increments.
      - After the next address is registered, valid stays high.
      - Back-to-back acceptance gives 1 address per cycle.
    - When the final address is consumed (last row, last layer, last iteration), next state is DONE.
  - DONE: one cycle.
    - done_o=1, addr_valid_o=0, busy_o=0.
    - Next state is IDLE.
- busy_o=1 in PREP and RUN only.
- start_i outside IDLE is ignored.
- addr_ready_i is ignored while addr_valid_o=0.
- Latency: start_i to first addr_valid_o = 2 cycles. Final accept to done_o = 1 cycle.
- Total addresses per schedule = iter × BASE_NUM × ROW_NUM.

Optional Feature:
- Macro: MSGPASS_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, 16 bits.
  - Counts cycles in RUN with addr_valid_o=1 and addr_ready_i=0; saturates at 16'hFFFF.
  - Cleared on rst and on an accepted start_i.
  - Holds its value after DONE.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset/idle: assert rst for 3 cycles, hold addr_ready_i=1 → all outputs 0, table reads back 0 (first address is 0 after a start), no valid.
- Basic schedule:
  - Stimulus: table = {8'h00, 8'h20, 8'h40, 8'h60}, iter_num_i=1, ready tied 1.
  - Response: valid asserts 2 cycles after start; 32 addresses 00..07, 20..27, 40..47, 60..67, in consecutive cycles; layer_last_o on 07/27/47/67; done_o 1 cycle after address 67.
- Backpressure:
  - Stimulus: same setup; addr_ready_i toggled in a 1-0-0 pattern.
  - Response: address sequence unchanged; each address held stable while ready=0; with MSGPASS_SCHED_STALL_CNT_EN, stall_cnt_o = 64 at done.
- Wrap and multi-iteration:
  - Stimulus: table[3]=8'hFC, iter_num_i=2.
  - Response: layer 3 emits FC, FD, FE, FF, 00, 01, 02, 03; the full 32-address sequence repeats twice (64 total); a single done_o.
- Illegal controls:
  - cfg_we_i asserted and start_i re-pulsed mid-RUN → table unchanged, schedule unaffected.
  - iter_num_i=0 → exactly 32 addresses.
  - cfg_we_i and start_i in the same IDLE cycle → the first address reflects the new table[0].
- Reset mid-operation: assert rst after 10 accepted addresses → next cycle valid=0, busy_o=0, no done_o; a new start restarts from table[0]+0.

Source files
------------

// File: rtl/msgpass_rd_addr_sched.sv
// Read-address scheduler for the LDPC message-pass buffer.
// Walks iterations (outer), layers (middle) and rows (inner), emitting
// table[layer] + row per address over a valid/ready handshake.
// Optional build macro: MSGPASS_SCHED_STALL_CNT_EN adds stall_cnt_o, a
// saturating count of RUN cycles where an address waited on the consumer.
//
// Handshake: an address is transferred on a rising edge where
// addr_valid_o=1 and addr_ready_i=1. While valid is high and ready is low,
// address, layer_id_o and layer_last_o are held. addr_ready_i is don't-care
// while valid is low.
module msgpass_rd_addr_sched #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_NUM   = 4,
    parameter int ROW_NUM    = 8,
    parameter int ITER_WIDTH = 4,
    localparam int SEL_W     = (BASE_NUM > 1) ? $clog2(BASE_NUM) : 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  cfg_we_i,
    input  logic [SEL_W-1:0]      cfg_sel_i,
    input  logic [ADDR_WIDTH-1:0] cfg_baseAddr_i,
    input  logic                  start_i,
    input  logic [ITER_WIDTH-1:0] iter_num_i,
    output logic [ADDR_WIDTH-1:0] msgPass_rdAddr_o,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic [SEL_W-1:0]      layer_id_o,
    output logic                  layer_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            state_dbg_o
`ifdef MSGPASS_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt_o
`endif
);

    localparam int ROW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROW_NUM - 1);
    localparam logic [SEL_W-1:0] LAYER_LAST = SEL_W'(BASE_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] table_q [BASE_NUM];
    logic [ITER_WIDTH-1:0] iter_lim_q, iter_lim_d;
    logic [ITER_WIDTH-1:0] iter_cnt_q, iter_cnt_d;
    logic [SEL_W-1:0]      layer_cnt_q, layer_cnt_d;
    logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]      layer_q, layer_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic accept;
    logic row_wrap;
    logic layer_wrap;
    logic iter_wrap;
    logic final_acc;

    assign accept     = (state_q == RUN) && valid_q && addr_ready_i;
    assign row_wrap   = (row_cnt_q == ROW_LAST);
    assign layer_wrap = (layer_cnt_q == LAYER_LAST);
    assign iter_wrap  = (iter_cnt_q == (iter_lim_q - ITER_WIDTH'(1)));
    assign final_acc  = accept && row_wrap && layer_wrap && iter_wrap;

    // State, counters, output registers and the base table.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            iter_lim_q  <= '0;
            iter_cnt_q  <= '0;
            layer_cnt_q <= '0;
            row_cnt_q   <= '0;
            addr_q      <= '0;
            layer_q     <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < BASE_NUM; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            iter_lim_q  <= iter_lim_d;
            iter_cnt_q  <= iter_cnt_d;
            layer_cnt_q <= layer_cnt_d;
            row_cnt_q   <= row_cnt_d;
            addr_q      <= addr_d;
            layer_q     <= layer_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            // Out-of-range selects match no entry and are dropped.
            if (state_q == IDLE && cfg_we_i) begin
                for (int i = 0; i < BASE_NUM; i++) begin
                    if (cfg_sel_i == SEL_W'(i)) begin
                        table_q[i] <= cfg_baseAddr_i;
                    end
                end
            end
        end
    end

    // Next-state and loop-counter logic.
    always_comb begin
        state_d     = state_q;
        iter_lim_d  = iter_lim_q;
        iter_cnt_d  = iter_cnt_q;
        layer_cnt_d = layer_cnt_q;
        row_cnt_d   = row_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = PREP;
                    iter_lim_d  = (iter_num_i == '0) ? ITER_WIDTH'(1) : iter_num_i;
                    iter_cnt_d  = '0;
                    layer_cnt_d = '0;
                    row_cnt_d   = '0;
                end
            end
            PREP: state_d = RUN;
            RUN: begin
                if (accept) begin
                    row_cnt_d = row_wrap ? '0 : row_cnt_q + ROW_W'(1);
                    if (row_wrap) begin
                        layer_cnt_d = layer_wrap ? '0 : layer_cnt_q + SEL_W'(1);
                        if (layer_wrap) begin
                            iter_cnt_d = iter_cnt_q + ITER_WIDTH'(1);
                        end
                    end
                    if (final_acc) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs: the next address is computed from the next counters.
    always_comb begin
        addr_d  = addr_q;
        layer_d = layer_q;
        last_d  = last_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: busy_d = start_i;
            PREP: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                addr_d  = table_q[layer_cnt_q] + ADDR_WIDTH'(row_cnt_q);
                layer_d = layer_cnt_q;
                last_d  = (row_cnt_q == ROW_LAST);
            end
            RUN: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                if (final_acc) begin
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (accept) begin
                    addr_d  = table_q[layer_cnt_d] + ADDR_WIDTH'(row_cnt_d);
                    layer_d = layer_cnt_d;
                    last_d  = (row_cnt_d == ROW_LAST);
                end
            end
            default: ;
        endcase
    end

    assign msgPass_rdAddr_o = addr_q;
    assign addr_valid_o     = valid_q;
    assign layer_id_o       = layer_q;
    assign layer_last_o     = last_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign state_dbg_o      = state_q;

`ifdef MSGPASS_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of RUN cycles where the presented address was not taken.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start_i) begin
            stall_cnt_d = '0;
        end else if (state_q == RUN && valid_q && !addr_ready_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_msgpass_rd_addr_sched.sv
// Self-checking bench for msgpass_rd_addr_sched.
// The reference schedule is the plain nested iteration/layer/row loop over a
// local copy of the base table; the bench records what the DUT emits and
// compares sequence, handshake stability and cycle timing.
module tb_msgpass_rd_addr_sched;

    localparam int MAX_CYC = 2000;

    logic       sys_clk;
    logic       rst;
    logic       cfg_we_i;
    logic [1:0] cfg_sel_i;
    logic [7:0] cfg_baseAddr_i;
    logic       start_i;
    logic [3:0] iter_num_i;
    logic [7:0] msgPass_rdAddr_o;
    logic       addr_valid_o;
    logic       addr_ready_i;
    logic [1:0] layer_id_o;
    logic       layer_last_o;
    logic       busy_o;
    logic       done_o;
    logic [1:0] state_dbg_o;
`ifdef MSGPASS_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    msgpass_rd_addr_sched dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .cfg_we_i         (cfg_we_i),
        .cfg_sel_i        (cfg_sel_i),
        .cfg_baseAddr_i   (cfg_baseAddr_i),
        .start_i          (start_i),
        .iter_num_i       (iter_num_i),
        .msgPass_rdAddr_o (msgPass_rdAddr_o),
        .addr_valid_o     (addr_valid_o),
        .addr_ready_i     (addr_ready_i),
        .layer_id_o       (layer_id_o),
        .layer_last_o     (layer_last_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .state_dbg_o      (state_dbg_o)
`ifdef MSGPASS_SCHED_STALL_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    // Clock and counters.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference table and expected queues.
    logic [7:0] tbl_m [4];
    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    logic [1:0] exp_layer_q[$];

    // Observations recorded by run_schedule.
    logic [7:0] obs_addr[$];
    logic       obs_last[$];
    logic [1:0] obs_layer[$];
    int first_valid_cyc, done_cyc, done_cnt, hold_err, busy_err, last_acc_cyc;
    logic [15:0] stall_at_done;

    // Reference schedule: iterations x layers x rows, modulo-256 addresses.
    task automatic build_exp(input int iters);
        int n;
        n = (iters == 0) ? 1 : iters;
        exp_q.delete();
        exp_last_q.delete();
        exp_layer_q.delete();
        for (int it = 0; it < n; it++)
            for (int l = 0; l < 4; l++)
                for (int r = 0; r < 8; r++) begin
                    exp_q.push_back(8'(int'(tbl_m[l]) + r));
                    exp_last_q.push_back(r == 7);
                    exp_layer_q.push_back(2'(l));
                end
    endtask

    task automatic cfg_write(input int sel, input logic [7:0] d);
        cfg_we_i       = 1'b1;
        cfg_sel_i      = 2'(sel);
        cfg_baseAddr_i = d;
        @(posedge sys_clk); #1;
        cfg_we_i = 1'b0;
        tbl_m[sel] = d;
    endtask

    // Driver/recorder: starts a schedule and records every accepted address.
    // mode 0: ready always 1; mode 1: ready 1-0-0 from the start cycle; else random.
    task automatic run_schedule(input int iters, input int mode, input bit inject,
                                input bit same_cfg, input logic [7:0] same_data);
        logic [10:0] held;
        bit          holding;
        bit          rdy;
        obs_addr.delete();
        obs_last.delete();
        obs_layer.delete();
        first_valid_cyc = -1;
        done_cyc        = -1;
        done_cnt        = 0;
        hold_err        = 0;
        busy_err        = 0;
        last_acc_cyc    = -1;
        stall_at_done   = '0;
        holding         = 1'b0;
        start_i    = 1'b1;
        iter_num_i = 4'(iters);
        if (same_cfg) begin
            cfg_we_i       = 1'b1;
            cfg_sel_i      = 2'd0;
            cfg_baseAddr_i = same_data;
        end
        @(posedge sys_clk); #1;
        start_i  = 1'b0;
        cfg_we_i = 1'b0;
        for (int cyc = 1; cyc < MAX_CYC; cyc++) begin
            if (holding && ({msgPass_rdAddr_o, layer_id_o, layer_last_o} !== held || addr_valid_o !== 1'b1))
                hold_err++;
            if (addr_valid_o === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done_o === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
`ifdef MSGPASS_SCHED_STALL_CNT_EN
                    stall_at_done = stall_cnt_o;
`endif
                end
                if (busy_o !== 1'b0 || addr_valid_o !== 1'b0) busy_err++;
            end else if (done_cyc < 0) begin
                if (busy_o !== 1'b1) busy_err++;
            end else begin
                if (busy_o !== 1'b0 || addr_valid_o !== 1'b0) busy_err++;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            addr_ready_i = rdy;
            if (inject && cyc >= 5 && cyc <= 8) begin
                cfg_we_i       = 1'b1;
                cfg_sel_i      = 2'(cyc);
                cfg_baseAddr_i = 8'hAA;
                start_i        = 1'b1;
                iter_num_i     = 4'd3;
            end else begin
                cfg_we_i = 1'b0;
                start_i  = 1'b0;
            end
            if (addr_valid_o === 1'b1 && rdy) begin
                obs_addr.push_back(msgPass_rdAddr_o);
                obs_last.push_back(layer_last_o);
                obs_layer.push_back(layer_id_o);
                last_acc_cyc = cyc;
                holding = 1'b0;
            end else if (addr_valid_o === 1'b1) begin
                holding = 1'b1;
                held = {msgPass_rdAddr_o, layer_id_o, layer_last_o};
            end else begin
                holding = 1'b0;
            end
            @(posedge sys_clk); #1;
        end
        addr_ready_i = 1'b0;
        start_i      = 1'b0;
        cfg_we_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr_ready_i = 1'b1;
        repeat (3) begin
            @(posedge sys_clk); #1;
            tests_run++;
            if ({msgPass_rdAddr_o, addr_valid_o, layer_id_o, layer_last_o, busy_o, done_o} !== 14'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got addr=%h valid=%b layer=%0d last=%b busy=%b done=%b, expected all 0",
                         msgPass_rdAddr_o, addr_valid_o, layer_id_o, layer_last_o, busy_o, done_o);
            end
        end
        rst = 1'b0;
        addr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) tbl_m[i] = 8'h00;
        run_schedule(1, 0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (obs_addr.size() < 1 || obs_addr[0] !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_table_zero: got first addr=%h (count %0d), expected 00",
                     (obs_addr.size() > 0) ? obs_addr[0] : 8'hxx, obs_addr.size());
        end
    endtask

    task automatic test_basic();
        cfg_write(0, 8'h00); cfg_write(1, 8'h20); cfg_write(2, 8'h40); cfg_write(3, 8'h60);
        build_exp(1);
        run_schedule(1, 0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (obs_addr.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d addresses, expected %0d", obs_addr.size(), exp_q.size());
        end else for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if ({obs_addr[i], obs_layer[i], obs_last[i]} !== {exp_q[i], exp_layer_q[i], exp_last_q[i]}) begin
                tests_failed++;
                $display("FAIL basic_seq[%0d]: got addr=%h layer=%0d last=%b, expected addr=%h layer=%0d last=%b",
                         i, obs_addr[i], obs_layer[i], obs_last[i], exp_q[i], exp_layer_q[i], exp_last_q[i]);
            end
        end
        tests_run++;
        if (first_valid_cyc != 2 || done_cyc != 32 + 2 || done_cnt != 1 || busy_err != 0) begin
            tests_failed++;
            $display("FAIL basic_timing: got first_valid=%0d done_cyc=%0d done_cnt=%0d busy_err=%0d, expected 2 34 1 0",
                     first_valid_cyc, done_cyc, done_cnt, busy_err);
        end
    endtask

    task automatic test_backpressure();
        build_exp(1);
        run_schedule(1, 1, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (obs_addr.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d addresses, expected %0d", obs_addr.size(), exp_q.size());
        end else for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if ({obs_addr[i], obs_layer[i], obs_last[i]} !== {exp_q[i], exp_layer_q[i], exp_last_q[i]}) begin
                tests_failed++;
                $display("FAIL bp_seq[%0d]: got addr=%h layer=%0d last=%b, expected addr=%h layer=%0d last=%b",
                         i, obs_addr[i], obs_layer[i], obs_last[i], exp_q[i], exp_layer_q[i], exp_last_q[i]);
            end
        end
        tests_run++;
        if (hold_err != 0 || done_cyc != 3 * 32 + 2 || done_cnt != 1 || busy_err != 0) begin
            tests_failed++;
            $display("FAIL bp_hold_timing: got hold_err=%0d done_cyc=%0d done_cnt=%0d busy_err=%0d, expected 0 98 1 0",
                     hold_err, done_cyc, done_cnt, busy_err);
        end
`ifdef MSGPASS_SCHED_STALL_CNT_EN
        tests_run++;
        if (stall_at_done !== 16'd64) begin
            tests_failed++;
            $display("FAIL bp_stall_cnt: got %0d, expected 64", stall_at_done);
        end
`endif
    endtask

    task automatic test_wrap_multi_iter();
        cfg_write(3, 8'hFC);
        build_exp(2);
        run_schedule(2, 2, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (obs_addr.size() != 64) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d addresses, expected 64", obs_addr.size());
        end else for (int i = 0; i < 64; i++) begin
            tests_run++;
            if ({obs_addr[i], obs_layer[i], obs_last[i]} !== {exp_q[i], exp_layer_q[i], exp_last_q[i]}) begin
                tests_failed++;
                $display("FAIL wrap_seq[%0d]: got addr=%h layer=%0d last=%b, expected addr=%h layer=%0d last=%b",
                         i, obs_addr[i], obs_layer[i], obs_last[i], exp_q[i], exp_layer_q[i], exp_last_q[i]);
            end
        end
        tests_run++;
        if (hold_err != 0 || done_cnt != 1 || done_cyc != last_acc_cyc + 1 || busy_err != 0) begin
            tests_failed++;
            $display("FAIL wrap_done: got hold_err=%0d done_cnt=%0d done_cyc=%0d last_accept=%0d busy_err=%0d, expected 0 1 last+1 0",
                     hold_err, done_cnt, done_cyc, last_acc_cyc, busy_err);
        end
    endtask

    task automatic test_illegal_controls();
        build_exp(1);
        run_schedule(1, 0, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (obs_addr.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL illegal_count: got %0d addresses, expected %0d", obs_addr.size(), exp_q.size());
        end else for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_addr[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL illegal_seq[%0d]: got %h, expected %h", i, obs_addr[i], exp_q[i]);
            end
        end
        tests_run++;
        if (done_cnt != 1 || done_cyc != 34) begin
            tests_failed++;
            $display("FAIL illegal_done: got done_cnt=%0d done_cyc=%0d, expected 1 34", done_cnt, done_cyc);
        end
    endtask

    task automatic test_iter_zero();
        for (int i = 0; i < 4; i++) cfg_write(i, 8'($urandom));
        build_exp(0);
        run_schedule(0, 2, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (obs_addr.size() != 32 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL iter_zero_count: got %0d addresses done_cnt=%0d, expected 32 1", obs_addr.size(), done_cnt);
        end else for (int i = 0; i < 32; i++) begin
            tests_run++;
            if (obs_addr[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL iter_zero_seq[%0d]: got %h, expected %h", i, obs_addr[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_cfg_start_same();
        logic [7:0] d;
        d = 8'($urandom_range(1, 255));
        tbl_m[0] = d;
        build_exp(1);
        run_schedule(1, 0, 1'b0, 1'b1, d);
        tests_run++;
        if (obs_addr.size() != 32 || obs_addr[0] !== d) begin
            tests_failed++;
            $display("FAIL cfg_start_same: got count=%0d first=%h, expected 32 %h",
                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 8'hxx, d);
        end else for (int i = 0; i < 32; i++) begin
            tests_run++;
            if (obs_addr[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL cfg_start_seq[%0d]: got %h, expected %h", i, obs_addr[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int iters;
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 4; i++) cfg_write(i, 8'($urandom));
            iters = $urandom_range(1, 3);
            build_exp(iters);
            run_schedule(iters, 2, 1'b0, 1'b0, 8'h00);
            tests_run++;
            if (obs_addr.size() != exp_q.size() || hold_err != 0 || done_cnt != 1 || busy_err != 0) begin
                tests_failed++;
                $display("FAIL random_%0d: got count=%0d hold_err=%0d done_cnt=%0d busy_err=%0d, expected %0d 0 1 0",
                         rnd, obs_addr.size(), hold_err, done_cnt, busy_err, exp_q.size());
            end else for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if ({obs_addr[i], obs_layer[i], obs_last[i]} !== {exp_q[i], exp_layer_q[i], exp_last_q[i]}) begin
                    tests_failed++;
                    $display("FAIL random_%0d_seq[%0d]: got addr=%h layer=%0d last=%b, expected addr=%h layer=%0d last=%b",
                             rnd, i, obs_addr[i], obs_layer[i], obs_last[i], exp_q[i], exp_layer_q[i], exp_last_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int accepted;
        int dn;
        accepted = 0;
        dn = 0;
        for (int i = 0; i < 4; i++) cfg_write(i, 8'($urandom));
        build_exp(1);
        start_i = 1'b1;
        iter_num_i = 4'd1;
        @(posedge sys_clk); #1;
        start_i = 1'b0;
        addr_ready_i = 1'b1;
        for (int cyc = 1; cyc < 40 && accepted < 10; cyc++) begin
            if (done_o === 1'b1) dn++;
            if (addr_valid_o === 1'b1) begin
                tests_run++;
                if (msgPass_rdAddr_o !== exp_q[accepted]) begin
                    tests_failed++;
                    $display("FAIL mid_pre_seq[%0d]: got %h, expected %h", accepted, msgPass_rdAddr_o, exp_q[accepted]);
                end
                accepted++;
            end
            @(posedge sys_clk); #1;
        end
        rst = 1'b1;
        @(posedge sys_clk); #1;
        rst = 1'b0;
        tests_run++;
        if (accepted != 10 || addr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got accepted=%0d valid=%b busy=%b done=%b, expected 10 0 0 0",
                     accepted, addr_valid_o, busy_o, done_o);
        end
        repeat (3) begin
            @(posedge sys_clk); #1;
            if (done_o === 1'b1) dn++;
        end
        tests_run++;
        if (dn != 0) begin
            tests_failed++;
            $display("FAIL mid_no_done: got %0d done pulses, expected 0", dn);
        end
        addr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) tbl_m[i] = 8'h00;
        build_exp(1);
        run_schedule(1, 0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (obs_addr.size() != 32 || obs_addr[0] !== exp_q[0] || obs_addr[31] !== exp_q[31] || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL mid_restart: got count=%0d first=%h done_cnt=%0d, expected 32 %h 1",
                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 8'hxx, done_cnt, exp_q[0]);
        end
    endtask

    // Test sequence and final report.
    initial begin
        rst            = 1'b1;
        cfg_we_i       = 1'b0;
        cfg_sel_i      = 2'd0;
        cfg_baseAddr_i = 8'h00;
        start_i        = 1'b0;
        iter_num_i     = 4'd0;
        addr_ready_i   = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_multi_iter();
        test_illegal_controls();
        test_iter_zero();
        test_cfg_start_same();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
